// File: rtl/fv_bank_req_initiator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fv_bank_req_initiator_pkg                                       |
// | Brief    : Shared widths, FSM encoding and bank-controller packet types.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package fv_bank_req_initiator_pkg;

    localparam int NUM_EDGE_PE    = 4;
    localparam int PE_TAG_W       = $clog2(NUM_EDGE_PE);
    localparam int FV_BW          = 32;
    localparam int MAX_NODE_ID    = 64;
    localparam int NODE_ID_W      = $clog2(MAX_NODE_ID);
    localparam int LINES_PER_NODE = 8;
    localparam int LINE_CNT_W     = $clog2(LINES_PER_NODE + 1);
    localparam int LINE_IDX_W     = $clog2(LINES_PER_NODE);

    typedef logic [1:0] state_t;
    localparam state_t C_ST_IDLE     = 2'd0;
    localparam state_t C_ST_WR_BURST = 2'd1;
    localparam state_t C_ST_RD_ISSUE = 2'd2;
    localparam state_t C_ST_RD_WAIT  = 2'd3;

    typedef struct packed {
        logic                 valid;
        logic                 rd_wr;
        logic                 wr_eos;
        logic [NODE_ID_W-1:0] Node_id;
        logic [PE_TAG_W-1:0]  PE_tag;
        logic [FV_BW-1:0]     data;
    } req2output_sram_bank_t;

    typedef struct packed {
        logic                sos;
        logic                eos;
        logic [FV_BW-1:0]    FV_data;
        logic [PE_TAG_W-1:0] PE_tag;
    } fv_bank_cntl2edge_pe_t;

endpackage
`default_nettype wire

// File: rtl/fv_bank_req_initiator_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fv_rr_arbiter                                                   |
// | Brief    : One-hot round-robin arbiter; search starts after the last grant.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fv_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_req,
    input  logic             i_advance,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_gnt_valid
);

    logic [IDX_W-1:0] r_ptr;

    always_comb begin
        logic [IDX_W-1:0] w_cand;
        w_cand      = '0;
        o_gnt_idx   = '0;
        o_gnt_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_cand = IDX_W'((int'(r_ptr) + k) % N);
            if (!o_gnt_valid && i_req[w_cand]) begin
                o_gnt_valid = 1'b1;
                o_gnt_idx   = w_cand;
            end
        end
        for (int i = 0; i < N; i++) begin
            o_gnt[i] = o_gnt_valid && (o_gnt_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance && o_gnt_valid) begin
            r_ptr <= (o_gnt_idx == IDX_W'(N - 1)) ? '0 : o_gnt_idx + IDX_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fv_bank_req_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fv_bank_req_initiator                                           |
// | Brief    : Buffers node write-back bursts, arbitrates them against Edge PE |
// |            reads and drives the FV bank controller request packet.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fv_bank_req_initiator
    import fv_bank_req_initiator_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             update_phase,
    input  logic                             wb_valid,
    output logic                             wb_ready,
    input  logic [NODE_ID_W-1:0]             wb_node_id,
    input  logic [FV_BW-1:0]                 wb_data,
    input  logic                             wb_last,
    input  logic [NUM_EDGE_PE-1:0]           rd_req_valid,
    input  logic [NUM_EDGE_PE*NODE_ID_W-1:0] rd_req_node_id,
    output logic [NUM_EDGE_PE-1:0]           rd_grant,
    output logic [NUM_EDGE_PE-1:0]           rd_done,
    output req2output_sram_bank_t            req_pkt,
    input  fv_bank_cntl2edge_pe_t            rd_rsp,
    output logic                             busy,
    output logic                             err
);

    state_t                r_state;
    logic [FV_BW-1:0]      r_buf [LINES_PER_NODE];
    logic [LINE_CNT_W-1:0] r_count;
    logic [LINE_IDX_W-1:0] r_idx;
    logic [NODE_ID_W-1:0]  r_wb_node_id;
    logic [NODE_ID_W-1:0]  r_rd_node_id;
    logic [PE_TAG_W-1:0]   r_rd_tag;
    logic                  r_burst_complete;
    logic                  r_rd_first;
    logic                  r_err;

    logic                   w_ready_core;
    logic                   w_wb_fire;
    logic [LINE_CNT_W-1:0]  w_count_nxt;
    logic                   w_can_issue;
    logic                   w_grant_wr;
    logic                   w_grant_rd;
    logic                   w_last_beat;
    logic [NUM_EDGE_PE-1:0] w_arb_gnt;
    logic [PE_TAG_W-1:0]    w_arb_idx;
    logic                   w_arb_valid;
    logic [NODE_ID_W-1:0]   w_rd_node;
    logic                   w_unused_rsp;

    fv_rr_arbiter #(
        .N     (NUM_EDGE_PE),
        .IDX_W (PE_TAG_W)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst         (reset),
        .i_req       (rd_req_valid),
        .i_advance   (w_grant_rd),
        .o_gnt       (w_arb_gnt),
        .o_gnt_idx   (w_arb_idx),
        .o_gnt_valid (w_arb_valid)
    );

    // Read-return payload goes straight to the PEs; only framing and tag matter here.
    assign w_unused_rsp = ^{rd_rsp.FV_data, w_arb_gnt};

    assign w_ready_core = (r_state != C_ST_WR_BURST) && !r_burst_complete
                          && (r_count < LINE_CNT_W'(LINES_PER_NODE));
    assign wb_ready     = w_ready_core && !reset;
    assign w_wb_fire    = wb_valid && w_ready_core;
    assign w_count_nxt  = r_count + LINE_CNT_W'(1);

    // When both a finished burst and a read are waiting, r_rd_first decides and then flips.
    assign w_can_issue = (r_state == C_ST_IDLE) && update_phase;
    assign w_grant_wr  = w_can_issue && r_burst_complete && (!w_arb_valid || !r_rd_first);
    assign w_grant_rd  = w_can_issue && w_arb_valid && !w_grant_wr;
    assign w_last_beat = (r_state == C_ST_WR_BURST)
                         && ((LINE_CNT_W'(r_idx) + LINE_CNT_W'(1)) == r_count);

    always_comb begin
        w_rd_node = '0;
        for (int i = 0; i < NUM_EDGE_PE; i++) begin
            if (w_arb_idx == PE_TAG_W'(i)) begin
                w_rd_node = rd_req_node_id[i*NODE_ID_W +: NODE_ID_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wb_fire) begin
            r_buf[r_count[LINE_IDX_W-1:0]] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= C_ST_IDLE;
            r_count          <= '0;
            r_idx            <= '0;
            r_wb_node_id     <= '0;
            r_rd_node_id     <= '0;
            r_rd_tag         <= '0;
            r_burst_complete <= 1'b0;
            r_rd_first       <= 1'b0;
            r_err            <= 1'b0;
        end else begin
            if (w_wb_fire) begin
                if (r_count == '0) begin
                    r_wb_node_id <= wb_node_id;
                end
                r_count <= w_count_nxt;
                if (wb_last || (w_count_nxt == LINE_CNT_W'(LINES_PER_NODE))) begin
                    r_burst_complete <= 1'b1;
                end
                if (!wb_last && (w_count_nxt == LINE_CNT_W'(LINES_PER_NODE))) begin
                    r_err <= 1'b1;
                end
            end
            if ((r_state == C_ST_RD_WAIT) && (rd_rsp.sos || rd_rsp.eos)
                && (rd_rsp.PE_tag != r_rd_tag)) begin
                r_err <= 1'b1;
            end
            if (w_can_issue && r_burst_complete && w_arb_valid) begin
                r_rd_first <= !r_rd_first;
            end
            case (r_state)
                C_ST_IDLE: begin
                    if (w_grant_wr) begin
                        r_state <= C_ST_WR_BURST;
                        r_idx   <= '0;
                    end else if (w_grant_rd) begin
                        r_state      <= C_ST_RD_ISSUE;
                        r_rd_tag     <= w_arb_idx;
                        r_rd_node_id <= w_rd_node;
                    end
                end
                C_ST_WR_BURST: begin
                    if (w_last_beat) begin
                        r_state          <= C_ST_IDLE;
                        r_count          <= '0;
                        r_burst_complete <= 1'b0;
                        r_idx            <= '0;
                    end else begin
                        r_idx <= r_idx + LINE_IDX_W'(1);
                    end
                end
                C_ST_RD_ISSUE: r_state <= C_ST_RD_WAIT;
                C_ST_RD_WAIT: begin
                    if (rd_rsp.eos) begin
                        r_state <= C_ST_IDLE;
                    end
                end
                default: r_state <= C_ST_IDLE;
            endcase
        end
    end

    // Node_id/PE_tag stay on the read target while waiting; the controller addresses from them.
    always_comb begin
        req_pkt         = '0;
        req_pkt.Node_id = r_rd_node_id;
        req_pkt.PE_tag  = r_rd_tag;
        case (r_state)
            C_ST_WR_BURST: begin
                req_pkt.valid   = 1'b1;
                req_pkt.rd_wr   = 1'b1;
                req_pkt.wr_eos  = w_last_beat;
                req_pkt.Node_id = r_wb_node_id;
                req_pkt.data    = r_buf[r_idx];
            end
            C_ST_RD_ISSUE: req_pkt.valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_EDGE_PE; i++) begin
            rd_grant[i] = (r_state == C_ST_RD_ISSUE) && (r_rd_tag == PE_TAG_W'(i));
            rd_done[i]  = (r_state == C_ST_RD_WAIT) && rd_rsp.eos && (r_rd_tag == PE_TAG_W'(i));
        end
    end

    assign busy = (r_state != C_ST_IDLE) || (r_count != '0);
    assign err  = r_err;

endmodule
`default_nettype wire
